pc_next_seq: RTL and testbench
==============================

// Module: pc_next_seq
// PURPOSE
//  Next-PC sequencer driving pc_ff's control inputs (pc_inc, next_pc) from pipeline events:
//  branch/jump redirects from EX, hazard stalls, syscall halt requests.
//  Registers on posedge clk; pc_ff samples them on the following negedge of the same cycle.
//  Holds a redirect that arrives during a pipeline freeze; runs the halt handshake with pc_ff.
// PARAMETERS
//  PC_W        32  PC width (word-addressed; pc_ff increments by 1)
//  CNT_W       32  width of statistics counters
//  HALT_DELAY   3  cycles of pc_inc=STOP before pc_ff raises halt
//  HALT_TMO     8  cycles in HALTING without halt before halt_err
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  clr          in   1      synchronous active-high reset
//  current_pc   in   PC_W   pc_ff current_pc
//  halt         in   1      pc_ff halt
//  stall        in   1      ID load-use hazard: hold PC
//  freeze       in   1      whole-pipeline freeze (mem busy): hold PC, defer redirects
//  br_valid     in   1      EX branch resolved this cycle
//  br_taken     in   1      branch outcome, qualified by br_valid
//  br_target    in   PC_W   branch target
//  jmp_valid    in   1      EX jump (j/jal/jr) this cycle
//  jmp_target   in   PC_W   jump target
//  halt_req     in   1      syscall-halt decoded (pulse)
//  pc_inc       out  2      00 NORMAL, 01 REDIRECT, 10 HOLD, 11 STOP
//  next_pc      out  PC_W   value pc_ff loads when pc_inc!=00
//  flush        out  1      squash IF/ID, one cycle, with each issued redirect
//  halt_err     out  1      sticky: pc_ff did not halt within HALT_TMO
//  redirect_cnt out  CNT_W  redirects issued, saturating
//  stall_cnt    out  CNT_W  cycles spent in HOLD (pc_inc=10), saturating
// BEHAVIOUR
//  clr: state=RUN, pc_inc=00, next_pc=0, flush=0, halt_err=0, counters=0, pending cleared.
//  clr overrides every input on the same edge, including mid-HALTING and a pending redirect.
//  States: RUN, PEND (redirect held during freeze), HALTING, HALTED.
//  Redirect event: jmp_valid, or br_valid&br_taken. Jump wins if both; target = jmp_target.
//  Per-edge priority in RUN:
//   1 halt_req            -> HALTING; pc_inc=11, next_pc=current_pc.
//   2 redirect & !freeze  -> pc_inc=01, next_pc=target, flush=1, redirect_cnt++.
//   3 redirect & freeze   -> latch target, -> PEND; pc_inc=10, next_pc=current_pc.
//   4 stall|freeze        -> pc_inc=10, next_pc=current_pc.
//   5 else                -> pc_inc=00, next_pc=current_pc (don't-care).
//  A redirect beats stall: the stalled instruction is on the wrong path.
//  PEND: pc_inc=10 while freeze=1; a newer redirect overwrites the held target.
//   First edge with freeze=0: pc_inc=01, next_pc=held target, flush=1, redirect_cnt++, -> RUN.
//   halt_req in PEND: drop the held target, -> HALTING.
//  HALTING: pc_inc=11, next_pc=current_pc every cycle (STOP loads next_pc, so PC stays frozen).
//   Redirect/stall/freeze ignored. halt=1 -> HALTED.
//   halt still 0 after HALT_TMO cycles in HALTING -> halt_err=1 (sticky until clr); state stays.
//  HALTED: pc_inc=11, next_pc=current_pc; only clr exits.
//  halt_req while HALTING or HALTED: no effect.
//  Latency: an event sampled at posedge N reaches pc_ff at negedge N; PC changes before posedge N+1.
//  flush high only on the edge that issues pc_inc=01; never two consecutive cycles without a new event.
//  Counters saturate at all-ones, no wrap; stall_cnt counts every cycle with pc_inc=10.
//  Sequencer never emits HOLD/REDIRECT targets other than current_pc or a sampled/held target.
// TESTING
//  Reset, then idle 5 cycles -> pc_inc=00 each cycle; paired pc_ff PC 0->5; counters 0.
//  jmp_valid=1, jmp_target=0x40, with br_taken=1/br_target=0x80 same cycle
//   -> pc_inc=01, next_pc=0x40, flush=1 for 1 cycle, redirect_cnt=1.
//  freeze=1 for 3 cycles; br_taken=0x20 on first, jmp 0x30 on second
//   -> pc_inc=10 x3, then 01 with next_pc=0x30, flush=1, redirect_cnt=1, stall_cnt=3.
//  stall=1 plus taken branch to 0x10 same cycle -> pc_inc=01, next_pc=0x10, stall_cnt unchanged.
//  halt_req at PC=0x7 with paired pc_ff -> pc_inc=11; halt rises after 3 STOP cycles; PC stays 0x7;
//   later jmp/stall ignored; clr -> RUN, PC=0.
//  halt tied 0 after halt_req -> halt_err=1 exactly 8 cycles after entering HALTING; clr clears.

Source files
------------

// File: rtl/pc_next_seq.sv
// Next-PC sequencer for pc_ff.
// Turns EX redirects, hazard stalls, pipeline freezes and syscall halt requests into the
// registered pc_inc/next_pc pair that pc_ff samples on the following negedge. A redirect
// that arrives while the pipeline is frozen is held until the freeze lifts. The halt
// handshake with pc_ff is supervised by a timeout that raises a sticky error.
module pc_next_seq #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned HALT_DELAY = 3,
  parameter int unsigned HALT_TMO   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [PC_W-1:0]  current_pc,
  input  logic             halt,
  input  logic             stall,
  input  logic             freeze,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             jmp_valid,
  input  logic [PC_W-1:0]  jmp_target,
  input  logic             halt_req,
  output logic [1:0]       pc_inc,
  output logic [PC_W-1:0]  next_pc,
  output logic             flush,
  output logic             halt_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    StRun,
    StPend,
    StHalting,
    StHalted
  } state_e;

  localparam logic [1:0] IncNormal   = 2'b00;
  localparam logic [1:0] IncRedirect = 2'b01;
  localparam logic [1:0] IncHold     = 2'b10;
  localparam logic [1:0] IncStop     = 2'b11;

  // Timeout counter is sized to cover both the timeout and the expected pc_ff halt latency,
  // so a badly chosen HALT_TMO below HALT_DELAY still gets a counter wide enough to count it.
  localparam int unsigned TmoMax  = (HALT_TMO > HALT_DELAY) ? HALT_TMO : HALT_DELAY;
  localparam int unsigned TmoW    = $clog2(TmoMax + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(HALT_TMO - 1);

  state_e           state_q, state_d;
  logic [1:0]       pc_inc_q, pc_inc_d;
  logic [PC_W-1:0]  next_pc_q, next_pc_d;
  logic             flush_q, flush_d;
  logic             halt_err_q, halt_err_d;
  logic [PC_W-1:0]  held_q, held_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             redirect;
  logic [PC_W-1:0]  redirect_target;

  // Decode the EX redirect event; a jump wins over a taken branch in the same cycle.
  always_comb begin
    redirect        = jmp_valid | (br_valid & br_taken);
    redirect_target = jmp_valid ? jmp_target : br_target;
  end

  // Next-state and next-output decision; defaults give NORMAL with the PC unchanged.
  always_comb begin
    state_d    = state_q;
    pc_inc_d   = IncNormal;
    next_pc_d  = current_pc;
    flush_d    = 1'b0;
    halt_err_d = halt_err_q;
    held_d     = held_q;
    tmo_d      = tmo_q;

    unique case (state_q)
      StRun: begin
        if (halt_req) begin
          state_d  = StHalting;
          pc_inc_d = IncStop;
          tmo_d    = '0;
        end else if (redirect && !freeze) begin
          // A redirect beats a stall: the stalled instruction is on the wrong path.
          pc_inc_d  = IncRedirect;
          next_pc_d = redirect_target;
          flush_d   = 1'b1;
        end else if (redirect) begin
          held_d   = redirect_target;
          state_d  = StPend;
          pc_inc_d = IncHold;
        end else if (stall || freeze) begin
          pc_inc_d = IncHold;
        end
      end

      StPend: begin
        if (halt_req) begin
          held_d   = '0;
          state_d  = StHalting;
          pc_inc_d = IncStop;
          tmo_d    = '0;
        end else if (freeze) begin
          pc_inc_d = IncHold;
          if (redirect) begin
            held_d = redirect_target;
          end
        end else begin
          pc_inc_d  = IncRedirect;
          next_pc_d = held_q;
          flush_d   = 1'b1;
          state_d   = StRun;
        end
      end

      StHalting: begin
        // STOP reloads current_pc, so the PC stays frozen while pc_ff winds down.
        pc_inc_d = IncStop;
        if (halt) begin
          state_d = StHalted;
        end else if (tmo_q == TmoLast) begin
          halt_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      StHalted: begin
        pc_inc_d = IncStop;
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Saturating statistics counters, driven by what is about to be issued.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if ((pc_inc_d == IncRedirect) && (redirect_cnt_q != '1)) begin
      redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
    end
    if ((pc_inc_d == IncHold) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and output registers; clr overrides every other input on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= StRun;
      pc_inc_q       <= IncNormal;
      next_pc_q      <= '0;
      flush_q        <= 1'b0;
      halt_err_q     <= 1'b0;
      held_q         <= '0;
      tmo_q          <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_inc_q       <= pc_inc_d;
      next_pc_q      <= next_pc_d;
      flush_q        <= flush_d;
      halt_err_q     <= halt_err_d;
      held_q         <= held_d;
      tmo_q          <= tmo_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign pc_inc       = pc_inc_q;
  assign next_pc      = next_pc_q;
  assign flush        = flush_q;
  assign halt_err     = halt_err_q;
  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pc_next_seq.sv
// Bench for pc_next_seq: a paired pc_ff model closes the loop on current_pc/halt, and a
// behavioural reference model predicts every registered output each cycle.
module tb_pc_next_seq;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned CNT_W      = 4;  // narrow so saturation is reachable
  localparam int unsigned HALT_DELAY = 3;
  localparam int unsigned HALT_TMO   = 8;
  localparam int          CntMax     = (1 << CNT_W) - 1;

  localparam int MRun = 0, MPend = 1, MHalting = 2, MHalted = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             clr, halt, stall, freeze, br_valid, br_taken, jmp_valid, halt_req;
  logic [PC_W-1:0]  pc, br_target, jmp_target;
  logic [1:0]       pc_inc;
  logic [PC_W-1:0]  next_pc;
  logic             flush, halt_err;
  logic [CNT_W-1:0] redirect_cnt, stall_cnt;

  pc_next_seq #(
    .PC_W       (PC_W),
    .CNT_W      (CNT_W),
    .HALT_DELAY (HALT_DELAY),
    .HALT_TMO   (HALT_TMO)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .current_pc   (pc),
    .halt         (halt),
    .stall        (stall),
    .freeze       (freeze),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .halt_req     (halt_req),
    .pc_inc       (pc_inc),
    .next_pc      (next_pc),
    .flush        (flush),
    .halt_err     (halt_err),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;

  // Reference model state
  int              m_mode, m_hcyc, m_rcnt, m_scnt, m_inc;
  logic [PC_W-1:0] m_held, m_npc;
  logic            m_flush, m_err;

  // Paired pc_ff environment
  int   stop_run;
  logic halt_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the outputs the coming edge will register, from the current inputs.
  task automatic model_step();
    logic            redir;
    logic [PC_W-1:0] tgt;
    redir = jmp_valid || (br_valid && br_taken);
    tgt   = jmp_valid ? jmp_target : br_target;
    if (clr) begin
      m_mode = MRun; m_inc = 0; m_npc = '0; m_flush = 1'b0; m_err = 1'b0;
      m_rcnt = 0; m_scnt = 0; m_held = '0; m_hcyc = 0;
      return;
    end
    m_flush = 1'b0;
    m_npc   = pc;
    if (m_mode == MHalted) begin
      m_inc = 3;
    end else if (m_mode == MHalting) begin
      m_inc = 3;
      if (halt) m_mode = MHalted;
      else begin
        m_hcyc++;
        if (m_hcyc >= HALT_TMO) m_err = 1'b1;
      end
    end else if (halt_req) begin
      m_mode = MHalting; m_inc = 3; m_hcyc = 0;
    end else if (m_mode == MPend) begin
      if (freeze) begin
        m_inc = 2;
        if (redir) m_held = tgt;
      end else begin
        m_inc = 1; m_npc = m_held; m_flush = 1'b1; m_mode = MRun;
      end
    end else if (redir && !freeze) begin
      m_inc = 1; m_npc = tgt; m_flush = 1'b1;
    end else if (redir) begin
      m_held = tgt; m_mode = MPend; m_inc = 2;
    end else if (stall || freeze) begin
      m_inc = 2;
    end else begin
      m_inc = 0;
    end
    if (m_inc == 1 && m_rcnt < CntMax) m_rcnt++;
    if (m_inc == 2 && m_scnt < CntMax) m_scnt++;
  endtask

  // One clock: predict, let the edge happen, compare, then let pc_ff act on the negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pc_inc", 64'(pc_inc), 64'(m_inc));
    check("next_pc", 64'(next_pc), 64'(m_npc));
    check("flush", 64'(flush), 64'(m_flush));
    check("halt_err", 64'(halt_err), 64'(m_err));
    check("redirect_cnt", 64'(redirect_cnt), 64'(m_rcnt));
    check("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
    @(negedge clk);
    if (clr) begin
      pc = '0; halt = 1'b0; stop_run = 0;
    end else begin
      if (pc_inc == 2'b00) pc = pc + 1;
      else pc = next_pc;
      if (pc_inc == 2'b11) stop_run++;
      else stop_run = 0;
      if (halt_en && stop_run >= HALT_DELAY) halt = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    stall = 0; freeze = 0; br_valid = 0; br_taken = 0; jmp_valid = 0; halt_req = 0;
    br_target = '0; jmp_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
  endtask

  initial begin
    pc = '0; halt = 0; stop_run = 0; halt_en = 1;
    m_mode = MRun; m_inc = 0; m_npc = '0; m_flush = 0; m_err = 0;
    m_rcnt = 0; m_scnt = 0; m_held = '0; m_hcyc = 0;
    clr = 1;
    idle_inputs();

    // Reset then 5 idle cycles
    do_reset();
    check("reset_pc_inc", 64'(pc_inc), 64'd0);
    check("reset_next_pc", 64'(next_pc), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("idle_pc", 64'(pc), 64'd5);

    // Jump wins over a simultaneous taken branch
    jmp_valid = 1; jmp_target = 32'h40; br_valid = 1; br_taken = 1; br_target = 32'h80;
    tick();
    check("jmp_pc_inc", 64'(pc_inc), 64'd1);
    check("jmp_next_pc", 64'(next_pc), 64'h40);
    check("jmp_cnt", 64'(redirect_cnt), 64'd1);
    idle_inputs();
    tick();
    check("jmp_flush_drop", 64'(flush), 64'd0);

    // Redirects deferred through a 3-cycle freeze, newest target kept
    do_reset();
    freeze = 1; br_valid = 1; br_taken = 1; br_target = 32'h20;
    tick();
    br_valid = 0; br_taken = 0; jmp_valid = 1; jmp_target = 32'h30;
    tick();
    jmp_valid = 0;
    tick();
    check("frz_hold", 64'(pc_inc), 64'd2);
    freeze = 0;
    tick();
    check("frz_pc_inc", 64'(pc_inc), 64'd1);
    check("frz_next_pc", 64'(next_pc), 64'h30);
    check("frz_flush", 64'(flush), 64'd1);
    check("frz_stall_cnt", 64'(stall_cnt), 64'd3);
    check("frz_rcnt", 64'(redirect_cnt), 64'd1);

    // Redirect beats stall
    do_reset();
    stall = 1; br_valid = 1; br_taken = 1; br_target = 32'h10;
    tick();
    check("stl_pc_inc", 64'(pc_inc), 64'd1);
    check("stl_next_pc", 64'(next_pc), 64'h10);
    check("stl_stall_cnt", 64'(stall_cnt), 64'd0);
    idle_inputs();

    // Halt handshake at PC=7
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    check("halt_start_pc", 64'(pc), 64'd7);
    halt_req = 1;
    tick();
    halt_req = 0;
    check("halt_stop", 64'(pc_inc), 64'd3);
    tick();
    check("halt_not_yet", 64'(halt), 64'd0);
    tick();
    check("halt_rose", 64'(halt), 64'd1);
    tick();
    jmp_valid = 1; jmp_target = 32'h99; stall = 1; halt_req = 1;
    tick();
    check("halted_ignore", 64'(pc_inc), 64'd3);
    check("halted_pc", 64'(pc), 64'd7);
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
    check("halt_clr_inc", 64'(pc_inc), 64'd0);
    check("halt_clr_pc", 64'(pc), 64'd0);

    // Halt timeout
    halt_en = 0;
    do_reset();
    halt_req = 1;
    tick();
    halt_req = 0;
    for (int i = 0; i < HALT_TMO - 1; i++) tick();
    check("tmo_before", 64'(halt_err), 64'd0);
    tick();
    check("tmo_at", 64'(halt_err), 64'd1);
    tick();
    check("tmo_sticky", 64'(halt_err), 64'd1);
    do_reset();
    check("tmo_clr", 64'(halt_err), 64'd0);
    halt_en = 1;

    // Counter saturation
    for (int i = 0; i < CntMax + 4; i++) begin
      jmp_valid = 1; jmp_target = PC_W'(i * 3);
      tick();
    end
    jmp_valid = 0; stall = 1;
    for (int i = 0; i < CntMax + 4; i++) tick();
    stall = 0;
    check("sat_rcnt", 64'(redirect_cnt), 64'(CntMax));
    check("sat_scnt", 64'(stall_cnt), 64'(CntMax));

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      clr = ($urandom_range(0, 59) == 0);
      if (clr) halt_en = $urandom_range(0, 1) == 1;
      halt_req   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) freeze = ~freeze;
      stall      = ($urandom_range(0, 3) == 0);
      br_valid   = ($urandom_range(0, 2) == 0);
      br_taken   = $urandom_range(0, 1) == 1;
      br_target  = PC_W'($urandom);
      jmp_valid  = ($urandom_range(0, 4) == 0);
      jmp_target = PC_W'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
